counter_sched: RTL and testbench

Round-robin scheduler that shares one WIDTH-bit up counter with parallel load between NREQ requesters. Each requester submits a session: a start value and an end value. The scheduler grants one session at a time, loads the counter, counts it up to the end value, then reports completion. It sits between the requesting control blocks and the shared counter datapath, which it instantiates.

---
 rtl/counter_sched_pkg.sv | 40 ++++
 rtl/counter_sched_counter.sv | 24 ++
 rtl/counter_sched.sv | 129 ++++++++++++
 tb/tb_counter_sched.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_sched_pkg.sv
// Shared types and helpers for the round-robin counter scheduler.
package counter_sched_pkg;

  localparam int unsigned NreqDefault  = 4;
  localparam int unsigned WidthDefault = 8;

  // Upper bound on requesters; the pick function works on a vector of this size.
  localparam int unsigned MaxReq = 8;
  localparam int unsigned MaxIdW = 3;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDone
  } sched_state_t;

  typedef struct packed {
    logic              found;
    logic [MaxIdW-1:0] idx;
  } rr_pick_t;

  // Round-robin pick: search starts at last+1 and wraps modulo nreq.
  function automatic rr_pick_t rr_pick(input logic [MaxReq-1:0] valid,
                                       input logic [MaxIdW-1:0] last,
                                       input int unsigned       nreq);
    rr_pick_t    res;
    int unsigned cand;
    res = '0;
    for (int unsigned k = 1; k <= MaxReq; k++) begin
      cand = (32'(last) + k) % nreq;
      if (!res.found && (k <= nreq) && valid[cand[MaxIdW-1:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[MaxIdW-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/counter_sched_counter.sv
// Shared WIDTH-bit up counter with parallel load; load wins over enable.
module sched_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  input  logic             enable,
  output logic [WIDTH-1:0] out
);

  // Counter register; wraps naturally modulo 2^WIDTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out <= '0;
    end else if (load) begin
      out <= data;
    end else if (enable) begin
      out <= out + WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one up counter between NREQ requesters.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter  int unsigned NREQ  = NreqDefault,
  parameter  int unsigned WIDTH = WidthDefault,
  localparam int unsigned IdW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_start,
  input  logic [NREQ*WIDTH-1:0] req_end,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  pause,
  input  logic                  abort,
  output logic [WIDTH-1:0]      cnt_out,
  output logic                  busy,
  output logic [IdW-1:0]        owner,
  output logic                  done_valid,
  output logic [IdW-1:0]        done_id,
  output logic                  done_abort
);

  sched_state_t   state_q, state_d;
  logic [IdW-1:0] last_grant_q, last_grant_d;
  logic [IdW-1:0] owner_q, owner_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] end_q, end_d;
  logic           abort_q, abort_d;

  logic           cnt_load, cnt_en;
  logic [WIDTH-1:0] cnt;
  rr_pick_t       pick;
  logic [IdW-1:0] winner;

  assign pick   = rr_pick(MaxReq'(req_valid), MaxIdW'(last_grant_q), NREQ);
  assign winner = pick.idx[IdW-1:0];

  sched_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk    (clk),
    .reset  (reset),
    .data   (start_q),
    .load   (cnt_load),
    .enable (cnt_en),
    .out    (cnt)
  );

  // Next-state, session latching and counter control.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    start_d      = start_q;
    end_d        = end_q;
    abort_d      = abort_q;
    req_ready    = '0;
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
    done_valid   = 1'b0;
    done_abort   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick.found) begin
          req_ready[winner] = 1'b1;
          for (int i = 0; i < NREQ; i++) begin
            if (IdW'(i) == winner) begin
              start_d = req_start[i*WIDTH +: WIDTH];
              end_d   = req_end[i*WIDTH +: WIDTH];
            end
          end
          owner_d      = winner;
          last_grant_d = winner;
          abort_d      = 1'b0;
          state_d      = StLoad;
        end
      end
      StLoad: begin
        cnt_load = 1'b1;
        // An abort seen here is held and honoured on the first RUN cycle.
        if (abort) abort_d = 1'b1;
        state_d = StRun;
      end
      StRun: begin
        if (abort || abort_q) begin
          abort_d = 1'b1;
          state_d = StDone;
        end else if (cnt == end_q) begin
          state_d = StDone;
        end else begin
          cnt_en = !pause;
        end
      end
      StDone: begin
        done_valid = 1'b1;
        done_abort = abort_q;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Scheduler state; reset discards any session in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= IdW'(NREQ - 1);
      owner_q      <= '0;
      start_q      <= '0;
      end_q        <= '0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      start_q      <= start_d;
      end_q        <= end_d;
      abort_q      <= abort_d;
    end
  end

  assign cnt_out = cnt;
  assign busy    = (state_q != StIdle);
  assign owner   = owner_q;
  assign done_id = owner_q;

endmodule

// File: tb/tb_counter_sched.sv
// Scoreboard bench for counter_sched: expected completions are queued at accept.
module tb_counter_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IdW   = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_start;
  logic [NREQ*WIDTH-1:0] req_end;
  logic [NREQ-1:0]       req_ready;
  logic                  pause;
  logic                  abort;
  logic [WIDTH-1:0]      cnt_out;
  logic                  busy;
  logic [IdW-1:0]        owner;
  logic                  done_valid;
  logic [IdW-1:0]        done_id;
  logic                  done_abort;

  counter_sched #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_start  (req_start),
    .req_end    (req_end),
    .req_ready  (req_ready),
    .pause      (pause),
    .abort      (abort),
    .cnt_out    (cnt_out),
    .busy       (busy),
    .owner      (owner),
    .done_valid (done_valid),
    .done_id    (done_id),
    .done_abort (done_abort)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         id;
    logic       abrt;
    int         at;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  // Completion monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && done_valid) begin
      exp_t e;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done_id=%0d at cycle %0d, required no pulse",
                 done_id, cyc);
      end else begin
        e = sb.pop_front();
        checks++;
        if (done_id !== IdW'(e.id)) begin
          failures++;
          $display("FAIL done_id: got %0d required %0d", done_id, e.id);
        end
        checks++;
        if (done_abort !== e.abrt) begin
          failures++;
          $display("FAIL done_abort: got %0b required %0b", done_abort, e.abrt);
        end
        checks++;
        if (cyc != e.at) begin
          failures++;
          $display("FAIL done_cycle: got %0d required %0d", cyc, e.at);
        end
        checks++;
        if (cnt_out !== e.cnt) begin
          failures++;
          $display("FAIL done_cnt: got %h required %h", cnt_out, e.cnt);
        end
      end
    end
  end

  task automatic set_lane(input int id, input logic [7:0] s_val, input logic [7:0] e_val);
    req_start[id*WIDTH +: WIDTH] = s_val;
    req_end[id*WIDTH +: WIDTH]   = e_val;
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    req_valid = '0;
    pause     = 1'b0;
    abort     = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Raise one request, wait for its accept, queue the expected completion.
  // Returns at accept cycle T+1, #1 after the edge, with the request dropped.
  task automatic submit(input int id, input logic [7:0] s_val, input logic [7:0] e_val,
                        input logic exp_abort, input int offset, input logic [7:0] fin,
                        input bit track, output int t);
    bit got = 0;
    @(posedge clk);
    #1;
    set_lane(id, s_val, e_val);
    req_valid[id] = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (req_ready !== 4'b0) got = 1;
    end
    t = cyc;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL accept_timeout: got no req_ready, required req_ready[%0d]", id);
    end else if (req_ready !== (4'b1 << id)) begin
      failures++;
      $display("FAIL accept_onehot: got %b required %b", req_ready, 4'b1 << id);
    end else if (track) begin
      sb.push_back('{id, exp_abort, t + offset, fin});
    end
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: got %0d pending completions, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (cnt_out !== 8'h00) begin failures++; $display("FAIL reset_cnt: got %h required 00", cnt_out); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++;
    if (owner !== 2'd0) begin failures++; $display("FAIL reset_owner: got %0d required 0", owner); end
    checks++;
    if (done_id !== 2'd0) begin failures++; $display("FAIL reset_done_id: got %0d required 0", done_id); end
    checks++;
    if (done_valid !== 1'b0 || done_abort !== 1'b0) begin
      failures++;
      $display("FAIL reset_done: got valid=%b abort=%b required 0 0", done_valid, done_abort);
    end
    checks++;
    if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_ready: got %b required 0000", req_ready); end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_single();
    int t;
    // RUN T+2..T+6 (10..14), match at T+6, DONE at T+7.
    submit(0, 8'h10, 8'h14, 1'b0, 7, 8'h14, 1'b1, t);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || owner !== 2'd0 || req_ready !== 4'b0) begin
      failures++;
      $display("FAIL single_load: got busy=%b owner=%0d ready=%b required 1 0 0000",
               busy, owner, req_ready);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (cnt_out !== 8'(8'h10 + k)) begin
        failures++;
        $display("FAIL single_step%0d: got %h required %h", k, cnt_out, 8'(8'h10 + k));
      end
    end
    wait_drain();
  endtask

  task automatic test_wrap();
    int t;
    logic [7:0] seq [3];
    seq = '{8'hFE, 8'hFF, 8'h00};
    submit(2, 8'hFE, 8'h01, 1'b0, 6, 8'h01, 1'b1, t);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (cnt_out !== seq[k]) begin
        failures++;
        $display("FAIL wrap_step%0d: got %h required %h", k, cnt_out, seq[k]);
      end
    end
    wait_drain();
  endtask

  task automatic test_pause();
    int t;
    // Three pause cycles push DONE from T+7 to T+10.
    submit(1, 8'h10, 8'h14, 1'b0, 10, 8'h14, 1'b1, t);
    repeat (2) begin @(posedge clk); #1; end
    pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (cnt_out !== 8'h11) begin
        failures++;
        $display("FAIL pause_hold%0d: got %h required 11", k, cnt_out);
      end
      @(posedge clk);
      #1;
    end
    pause = 1'b0;
    wait_drain();
  endtask

  task automatic test_abort();
    int t;
    submit(3, 8'h10, 8'h14, 1'b1, 5, 8'h12, 1'b1, t);
    repeat (3) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(negedge clk);
    checks++;
    if (cnt_out !== 8'h12) begin failures++; $display("FAIL abort_at: got %h required 12", cnt_out); end
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (cnt_out !== 8'h12 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_frozen: got cnt=%h busy=%b required 12 0", cnt_out, busy);
    end
    wait_drain();
    // Abort during LOAD: first RUN cycle ends the session with the start value loaded.
    submit(0, 8'h20, 8'h30, 1'b1, 3, 8'h20, 1'b1, t);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    wait_drain();
  endtask

  task automatic test_fairness();
    int t, prev, exp_id;
    bit got;
    apply_reset();
    for (int i = 0; i < NREQ; i++) set_lane(i, 8'(i * 16 + 3), 8'(i * 16 + 3));
    req_valid = 4'hF;
    prev = 0;
    for (int n = 0; n < 5; n++) begin
      exp_id = n % NREQ;
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        if (req_ready !== 4'b0) got = 1;
      end
      t = cyc;
      checks++;
      if (!got || req_ready !== (4'b1 << exp_id)) begin
        failures++;
        $display("FAIL fair_grant%0d: got %b required %b", n, req_ready, 4'b1 << exp_id);
      end
      sb.push_back('{exp_id, 1'b0, t + 3, 8'(exp_id * 16 + 3)});
      if (n > 0) begin
        checks++;
        if (t - prev != 4) begin
          failures++;
          $display("FAIL fair_spacing%0d: got %0d required 4", n, t - prev);
        end
      end
      prev = t;
      @(posedge clk);
    end
    #1 req_valid = '0;
    wait_drain();
  endtask

  task automatic test_reset_mid_run();
    int t;
    bit got = 0;
    submit(1, 8'h00, 8'hC8, 1'b0, 0, 8'h00, 1'b0, t);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    checks++;
    if (cnt_out !== 8'h00 || busy !== 1'b0 || owner !== 2'd0) begin
      failures++;
      $display("FAIL midreset_out: got cnt=%h busy=%b owner=%0d required 00 0 0",
               cnt_out, busy, owner);
    end
    checks++;
    if (done_valid !== 1'b0 || done_abort !== 1'b0 || req_ready !== 4'b0) begin
      failures++;
      $display("FAIL midreset_ctl: got done=%b abort=%b ready=%b required 0 0 0000",
               done_valid, done_abort, req_ready);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    set_lane(0, 8'h33, 8'h33);
    set_lane(2, 8'h44, 8'h44);
    req_valid = 4'b0101;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (req_ready !== 4'b0) got = 1;
    end
    t = cyc;
    checks++;
    if (!got || req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL midreset_next: got %b required 0001", req_ready);
    end else begin
      sb.push_back('{0, 1'b0, t + 3, 8'h33});
    end
    @(posedge clk);
    #1 req_valid = '0;
    wait_drain();
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_start = '0;
    req_end   = '0;
    pause     = 1'b0;
    abort     = 1'b0;
    test_reset();
    test_single();
    test_wrap();
    test_pause();
    test_abort();
    test_fairness();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by time limit, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
